// File: rtl/apb_rr_master.sv
// APB master shared by NREQ local requesters.
// Requesters are served round-robin. Each transfer runs IDLE -> SETUP -> ACCESS -> IDLE.
// Each transfer ends with a one-cycle done or err pulse for the requester that was served.
// A wait counter aborts an ACCESS phase when PREADY stays low for TIMEOUT cycles.
// Setting TIMEOUT to 0 disables the timeout.
module apb_rr_master #(
  parameter int NREQ    = 2,
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          done,
  output logic [NREQ-1:0]          err,
  output logic [DWIDTH-1:0]        rdata,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [AWIDTH-1:0]        PADDR,
  output logic [DWIDTH-1:0]        PWDATA,
  input  logic [DWIDTH-1:0]        PRDATA,
  input  logic                     PREADY
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       rr_last_q, rr_last_d;   // last winner; also owner of the current transfer
  logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [AWIDTH-1:0]   paddr_q, paddr_d;
  logic [DWIDTH-1:0]   pwdata_q, pwdata_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [NREQ-1:0]     err_q, err_d;

  logic [NREQ-1:0]     elig_s;
  logic                found_s;
  logic [IW-1:0]       winner_s;
  logic [CW-1:0]       wait_inc_s;

  // A requester whose completion pulse is showing cannot be granted again in the same cycle.
  assign elig_s     = req & ~(done_q | err_q);
  assign wait_inc_s = wait_cnt_q + {{(CW-1){1'b0}}, 1'b1};

  // Round-robin pick: first eligible requester scanning from rr_last+1 around to rr_last.
  always_comb begin
    found_s  = 1'b0;
    winner_s = rr_last_q;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found_s && elig_s[(int'(rr_last_q) + k) % NREQ]) begin
        found_s  = 1'b1;
        winner_s = IW'((int'(rr_last_q) + k) % NREQ);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Transfer sequencing and next values for all registered outputs.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    wait_cnt_d = wait_cnt_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    rdata_d    = rdata_q;
    done_d     = '0;
    err_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = req_write[winner_s];
          paddr_d   = req_addr[int'(winner_s)*AWIDTH +: AWIDTH];
          pwdata_d  = req_wdata[int'(winner_s)*DWIDTH +: DWIDTH];
          rr_last_d = winner_s;
          state_d   = ST_SETUP;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          done_d[rr_last_q]  = 1'b1;
          state_d            = ST_IDLE;
          if (!pwrite_q) begin
            rdata_d = PRDATA;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          wait_cnt_d = wait_inc_s;
          if ((TIMEOUT != 0) && (wait_inc_s == CW'(TIMEOUT))) begin
            psel_d            = 1'b0;
            penable_d         = 1'b0;
            err_d[rr_last_q]  = 1'b1;
            state_d           = ST_IDLE;
          end else begin
            state_d           = ST_ACCESS;
          end
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears all outputs at once, even in the middle of a transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      rr_last_q  <= IW'(NREQ - 1);
      wait_cnt_q <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      rdata_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      wait_cnt_q <= wait_cnt_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign rdata   = rdata_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master (NREQ=2, 8-bit address/data, TIMEOUT=16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_apb_rr_master;

  logic        PCLK;
  logic        PRESETn;
  logic [1:0]  req;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  done;
  logic [1:0]  err;
  logic [7:0]  rdata;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [7:0]  PWDATA;
  logic [7:0]  PRDATA;
  logic        PREADY;

  int checks = 0;
  int errors = 0;

  apb_rr_master #(.NREQ(2), .AWIDTH(8), .DWIDTH(8), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .err(err),
    .rdata(rdata), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    PRESETn = 1'b0; req = 2'b00; req_write = 2'b00;
    req_addr = 16'h0000; req_wdata = 16'h0000; PRDATA = 8'h00; PREADY = 1'b1;

    // reset state
    tick(); tick();
    chk("rst_apb", {PSEL, PENABLE, PWRITE}, 32'h0);
    chk("rst_addr_data", {PADDR, PWDATA, rdata}, 32'h0);
    chk("rst_done_err", {done, err}, 32'h0);
    PRESETn = 1'b1;
    tick();
    chk("idle_no_grant", {PSEL, done, err}, 32'h0);

    // single write from requester 0
    req_write = 2'b01; req_addr = 16'h0004; req_wdata = 16'h00A5; req = 2'b01; PREADY = 1'b1;
    tick();
    chk("wr_setup", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {9'h0, 3'b101, 8'h04, 8'hA5, 4'h0} >> 4);
    chk("wr_setup_done", {done, err}, 32'h0);
    tick();
    chk("wr_access", {PSEL, PENABLE, PWDATA}, {22'h0, 2'b11, 8'hA5});
    chk("wr_access_done", done, 32'h0);
    tick();
    chk("wr_done", {done, err, PSEL, PENABLE}, {26'h0, 6'b010000});
    chk("wr_hold_pwdata", PWDATA, 32'hA5);
    chk("wr_rdata_untouched", rdata, 32'h00);
    req = 2'b00;
    tick();
    chk("wr_done_once", done, 32'h0);

    // read from requester 1 with three wait cycles
    req_write = 2'b00; req_addr = 16'h0800; PRDATA = 8'hFF; PREADY = 1'b0; req = 2'b10;
    tick();
    chk("rd_setup", {PSEL, PENABLE, PWRITE, PADDR}, {21'h0, 3'b100, 8'h08});
    tick();
    chk("rd_a1", {PSEL, PENABLE}, 32'h3);
    tick();
    tick();
    chk("rd_a3", {PSEL, PENABLE, done, err}, {26'h0, 6'b110000});
    tick();
    chk("rd_a4_rdata_old", rdata, 32'h00);
    PREADY = 1'b1; PRDATA = 8'h3C;
    tick();
    chk("rd_done", {done, err, PSEL, PENABLE}, {26'h0, 6'b100000});
    chk("rd_rdata", rdata, 32'h3C);
    req = 2'b00;
    tick();

    // round robin with both requests held continuously
    req_write = 2'b11; req_addr = 16'h2010; req_wdata = 16'h2211; PREADY = 1'b1; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_setup", {PSEL, PENABLE, PADDR}, (k % 2 == 0) ? {22'h0, 2'b10, 8'h10} : {22'h0, 2'b10, 8'h20});
      tick();
      tick();
      chk("rr_done", done, (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k == 3) begin
        req = 2'b00;
      end
    end
    tick();
    chk("rr_idle", {PSEL, done}, 32'h0);

    // timeout on requester 0
    req_write = 2'b00; req_addr = 16'h0030; PRDATA = 8'h99; PREADY = 1'b0; req = 2'b01;
    tick();
    chk("to_setup", {PSEL, PENABLE, PADDR}, {22'h0, 2'b10, 8'h30});
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("to_wait", {err, done, PSEL, PENABLE}, 32'h3);
    end
    tick();
    chk("to_err", {err, done, PSEL, PENABLE}, {26'h0, 6'b010000});
    chk("to_rdata_kept", rdata, 32'h3C);
    req = 2'b10; req_write = 2'b10; req_addr = 16'h4000; req_wdata = 16'h5A00; PREADY = 1'b1;
    tick();
    chk("to_next_setup", {err, PSEL, PWRITE, PADDR, PWDATA}, {14'h0, 2'b00, 2'b11, 8'h40, 8'h5A});
    tick();
    tick();
    chk("to_next_done", {done, err}, {28'h0, 4'b1000});
    req = 2'b00;
    tick();

    // requester 0 drops its request during ACCESS
    req_write = 2'b01; req_addr = 16'h0050; req_wdata = 16'h0077; PREADY = 1'b0; req = 2'b01;
    tick();
    tick();
    req = 2'b00;
    tick();
    chk("drop_wait", {done, PSEL, PENABLE}, 32'h3);
    PREADY = 1'b1;
    tick();
    chk("drop_done", {done, err, PWDATA}, {20'h0, 4'b0100, 8'h77});
    tick();
    chk("drop_done_once", done, 32'h0);
    tick();
    chk("drop_no_regrant", {PSEL, done}, 32'h0);

    // reset in the middle of ACCESS, then requester 0 must win first
    req_write = 2'b00; req_addr = 16'h0060; PREADY = 1'b0; req = 2'b01;
    tick();
    tick();
    tick();
    chk("rst_pre_access", {PSEL, PENABLE}, 32'h3);
    #3;
    PRESETn = 1'b0;
    #1;
    chk("rst_async_apb", {PSEL, PENABLE}, 32'h0);
    chk("rst_async_pulses", {done, err}, 32'h0);
    req = 2'b11; req_addr = 16'h7060;
    tick();
    tick();
    PRESETn = 1'b1; PREADY = 1'b1;
    tick();
    chk("rst_first_winner", {PSEL, PENABLE, PADDR}, {22'h0, 2'b10, 8'h60});
    chk("rst_no_pulse", {done, err}, 32'h0);
    tick();
    tick();
    chk("rst_winner_done", done, 32'h1);
    req = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
